// File: rtl/sub_4bit_lut_if.sv
// Operand/result bundle for the pipelined LUT subtractor.
// Master drives start/a/b/bin and slave returns ready/d/bout.
// No backpressure signal: the slave accepts one operand set every clock.
interface sub_4bit_lut_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  ready, d, bout
    );

    modport slave (
        input  start, a, b, bin,
        output ready, d, bout
    );
endinterface

// File: rtl/sub_4bit_lut.sv
// Pipelined ripple subtractor d = a - b - bin built from 2-bit LUT slices.
// Latency: WIDTH/2 clocks (result visible after edge N+NSTG-1), 1 result/clk.
// No backpressure: operands are accepted whenever start=1; consumers qualify with ready.
module sub_4bit_lut #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    sub_4bit_lut_if.slave bus
);
    // WIDTH is expected to be even and at least 2.
    localparam int NSTG = WIDTH / 2;

    // 2-bit subtract slice: index {a1,b1,a0,b0,bi} -> {bo,d1,d0}.
    function automatic logic [2:0] slice_lut(input logic [4:0] idx);
        logic [2:0] r;
        case (idx)
            5'd0:    r = 3'b000;
            5'd1:    r = 3'b111;
            5'd2:    r = 3'b111;
            5'd3:    r = 3'b110;
            5'd4:    r = 3'b001;
            5'd5:    r = 3'b000;
            5'd6:    r = 3'b000;
            5'd7:    r = 3'b111;
            5'd8:    r = 3'b110;
            5'd9:    r = 3'b101;
            5'd10:   r = 3'b101;
            5'd11:   r = 3'b100;
            5'd12:   r = 3'b111;
            5'd13:   r = 3'b110;
            5'd14:   r = 3'b110;
            5'd15:   r = 3'b101;
            5'd16:   r = 3'b010;
            5'd17:   r = 3'b001;
            5'd18:   r = 3'b001;
            5'd19:   r = 3'b000;
            5'd20:   r = 3'b011;
            5'd21:   r = 3'b010;
            5'd22:   r = 3'b010;
            5'd23:   r = 3'b001;
            5'd24:   r = 3'b000;
            5'd25:   r = 3'b111;
            5'd26:   r = 3'b111;
            5'd27:   r = 3'b110;
            5'd28:   r = 3'b001;
            5'd29:   r = 3'b000;
            5'd30:   r = 3'b000;
            5'd31:   r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [NSTG-1:0]  vld_d;
    logic [NSTG-1:0]  vld_q;
    logic             last_vld;   // an operation is entering the final stage this cycle
    logic [NSTG-1:0]  brw_w;      // registered borrow out of each stage
    logic [WIDTH-1:0] d_w;

    // Valid shift register: bit k marks stage k's registers as holding a live operation.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = bus.start;
        for (int j = 1; j < NSTG; j++) begin
            vld_d[j] = vld_q[j-1];
        end
    end

    // Valid bits clear on reset so in-flight work is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    if (NSTG == 1) begin : g_lv_single
        assign last_vld = bus.start;
    end else begin : g_lv_multi
        assign last_vld = vld_q[NSTG-2];
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        // Result of slice k still needs NSTG-1-k delay registers after its own.
        localparam int L = NSTG - k;

        logic [1:0] a_op;
        logic [1:0] b_op;
        logic       bi;
        logic [2:0] lut_o;
        logic [1:0] res_d [L];
        logic [1:0] res_q [L];
        logic       brw_d;
        logic       brw_q;

        if (k == 0) begin : g_in
            assign a_op = bus.a[1:0];
            assign b_op = bus.b[1:0];
            assign bi   = bus.bin;
        end else begin : g_skew
            logic [1:0] a_sk_q [k];
            logic [1:0] b_sk_q [k];

            // Delay this slice's operand bits by k clocks to meet the rippling borrow.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    a_sk_q <= '{default: '0};
                    b_sk_q <= '{default: '0};
                end else begin
                    a_sk_q[0] <= bus.a[2*k+1 -: 2];
                    b_sk_q[0] <= bus.b[2*k+1 -: 2];
                    for (int j = 1; j < k; j++) begin
                        a_sk_q[j] <= a_sk_q[j-1];
                        b_sk_q[j] <= b_sk_q[j-1];
                    end
                end
            end

            assign a_op = a_sk_q[k-1];
            assign b_op = b_sk_q[k-1];
            assign bi   = brw_w[k-1];
        end

        assign lut_o = slice_lut({a_op[1], b_op[1], a_op[0], b_op[0], bi});

        // Next state of the result chain; the output-facing register only loads valid results.
        always_comb begin
            res_d    = res_q;
            res_d[0] = lut_o[1:0];
            for (int j = 1; j < L; j++) begin
                res_d[j] = res_q[j-1];
            end
            if (!last_vld) begin
                res_d[L-1] = res_q[L-1];
            end
            brw_d = lut_o[2];
            if ((k == NSTG - 1) && !last_vld) begin
                brw_d = brw_q;
            end
        end

        // Slice result and borrow registers.
        always_ff @(posedge clk) begin
            if (!reset) begin
                res_q <= '{default: '0};
                brw_q <= 1'b0;
            end else begin
                res_q <= res_d;
                brw_q <= brw_d;
            end
        end

        assign d_w[2*k+1 -: 2] = res_q[L-1];
        assign brw_w[k]        = brw_q;
    end

    assign bus.ready = vld_q[NSTG-1];
    assign bus.d     = d_w;
    assign bus.bout  = brw_w[NSTG-1];
endmodule
